// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: register addresses,
// display mode encodings and STATUS field positions.
package led_pkg;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CLR    = 2'd3;

  // Display modes; the reserved code falls through to pass-through
  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_RSVD  = 2'd3
  } led_mode_e;

  // STATUS register field positions
  localparam int STAT_PHASE_BIT     = 0;
  localparam int STAT_POS_LSB       = 8;
  localparam int STAT_TICK_SEEN_BIT = 16;

  // Writes to CTRL or PERIOD restart the pattern timebase
  function automatic logic is_cfg_addr(input logic [1:0] addr);
    return (addr == ADDR_CTRL) || (addr == ADDR_PERIOD);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler: counts 0..period and pulses tick on the last count.
// A synchronous clear restarts the count and suppresses a coincident tick.
module led_prescaler
  import led_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;

  assign tick = (cnt == period) && !clr;

  // Count up and wrap; cnt above period (period lowered) also wraps at once
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr || (cnt >= period)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: sits between the LED PIO and the pins, applying a
// pass-through, blink or chase pattern timed by a programmable prescaler.
// Mode and rate are set over a zero-wait-state Avalon-MM slave.
module led_pattern_engine
  import led_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int PERIOD_W   = 24,
  parameter int PERIOD_RST = 12499999
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [LED_W-1:0] led_in,
  output logic [LED_W-1:0] led_out
);

  localparam int POS_W = (LED_W > 1) ? $clog2(LED_W) : 1;

  led_mode_e           mode;
  logic [PERIOD_W-1:0] period;
  logic                phase;
  logic [POS_W-1:0]    pos;
  logic                tick_seen;
  logic                tick;
  logic                wr_en;
  logic                cfg_wr;
  logic [LED_W-1:0]    chase_mask;
  logic                unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign cfg_wr       = wr_en && is_cfg_addr(address);
  assign chase_mask   = LED_W'(1) << pos;
  assign unused_wdata = &{1'b0, writedata[31:PERIOD_W]};

  led_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .clr    (cfg_wr),
    .tick   (tick)
  );

  // CTRL and PERIOD registers
  always_ff @(posedge clk) begin
    if (reset) begin
      mode   <= MODE_PASS;
      period <= PERIOD_W'(PERIOD_RST);
    end else if (wr_en) begin
      if (address == ADDR_CTRL) begin
        mode <= led_mode_e'(writedata[1:0]);
      end else if (address == ADDR_PERIOD) begin
        period <= writedata[PERIOD_W-1:0];
      end
    end
  end

  // Blink phase and chase position advance on every tick, restart on config writes
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= 1'b1;
      pos   <= '0;
    end else if (cfg_wr) begin
      phase <= 1'b1;
      pos   <= '0;
    end else if (tick) begin
      phase <= !phase;
      pos   <= (pos == POS_W'(LED_W - 1)) ? '0 : pos + POS_W'(1);
    end
  end

  // Sticky tick flag; a tick in the same cycle as a clear keeps it set
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_seen <= 1'b0;
    end else if (tick) begin
      tick_seen <= 1'b1;
    end else if (wr_en && (address == ADDR_CLR)) begin
      tick_seen <= 1'b0;
    end
  end

  // Pattern mux, registered towards the pins
  always_ff @(posedge clk) begin
    if (reset) begin
      led_out <= '0;
    end else begin
      case (mode)
        MODE_BLINK: led_out <= phase ? led_in : '0;
        MODE_CHASE: led_out <= led_in & chase_mask;
        default:    led_out <= led_in;
      endcase
    end
  end

  // Combinational read mux, no read side effects
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_CTRL:   readdata[1:0] = mode;
      ADDR_PERIOD: readdata[PERIOD_W-1:0] = period;
      ADDR_STATUS: begin
        readdata[STAT_PHASE_BIT]          = phase;
        readdata[STAT_POS_LSB +: POS_W]   = pos;
        readdata[STAT_TICK_SEEN_BIT]      = tick_seen;
      end
      default: readdata = '0;
    endcase
  end

endmodule
